// File: rtl/main_core.sv
// Multi-cycle RV32I-subset core: four fixed phases per instruction, with the
// instruction word and input data taken from ports and a registered output port.
module main_core #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_bus,
  output logic [XLEN-1:0] out_bus
);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} phase_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  phase_t          phase, phase_nxt;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] rs1_val, rs2_val, imm;

  logic [XLEN-1:0] res_q, npc_q;
  logic            wen_q, out_en_q;

  logic [XLEN-1:0] alu_b, res, npc, imm_dec;
  logic            wen, out_en;
  logic [4:0]      shamt;

  wire [6:0] opcode = ir[6:0];
  wire [2:0] funct3 = ir[14:12];
  wire [4:0] rd     = ir[11:7];

  // Phase register: strictly cycles through the four phases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase <= FETCH;
    else      phase <= phase_nxt;
  end

  // Next-phase sequencing.
  always_comb begin
    phase_nxt = FETCH;
    case (phase)
      FETCH:     phase_nxt = DECODE;
      DECODE:    phase_nxt = EXECUTE;
      EXECUTE:   phase_nxt = WRITEBACK;
      WRITEBACK: phase_nxt = FETCH;
      default:   phase_nxt = FETCH;
    endcase
  end

  // Immediate generation from the latched instruction, sign-extended to XLEN.
  always_comb begin
    imm_dec = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_dec = XLEN'(signed'({ir[31:12], 12'b0}));
      OPC_JAL:   imm_dec = XLEN'(signed'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      OPC_STORE: imm_dec = XLEN'(signed'({ir[31:25], ir[11:7]}));
      default:   imm_dec = XLEN'(signed'(ir[31:20]));
    endcase
  end

  // ALU, next-PC and writeback-control computation for the EXECUTE phase.
  always_comb begin
    res    = '0;
    npc    = pc + XLEN'(4);
    wen    = 1'b0;
    out_en = 1'b0;
    alu_b  = (opcode == OPC_OP) ? rs2_val : imm;
    shamt  = alu_b[4:0];
    case (opcode)
      OPC_LUI:   begin res = imm;                wen = 1'b1; end
      OPC_AUIPC: begin res = pc + imm;           wen = 1'b1; end
      OPC_JAL:   begin res = pc + XLEN'(4);      wen = 1'b1; npc = pc + imm; end
      OPC_JALR:  begin
        res = pc + XLEN'(4);
        wen = 1'b1;
        npc = (rs1_val + imm) & ~XLEN'(1);
      end
      OPC_OPIMM, OPC_OP: begin
        wen = 1'b1;
        case (funct3)
          3'b000: res = (opcode == OPC_OP && ir[30]) ? rs1_val - alu_b : rs1_val + alu_b;
          3'b001: res = rs1_val << shamt;
          3'b010: res = XLEN'($signed(rs1_val) < $signed(alu_b));
          3'b011: res = XLEN'(rs1_val < alu_b);
          3'b100: res = rs1_val ^ alu_b;
          3'b101: res = ir[30] ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
          3'b110: res = rs1_val | alu_b;
          default: res = rs1_val & alu_b;
        endcase
      end
      OPC_LOAD:  begin res = in_bus;  wen = 1'b1; end
      OPC_STORE: begin res = rs2_val; out_en = 1'b1; end
      default: ;
    endcase
    if (wen) out_en = 1'b1;
  end

  // Datapath state: IR, operands, registered results, register file, PC and output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir       <= '0;
      pc       <= RESET_PC;
      rs1_val  <= '0;
      rs2_val  <= '0;
      imm      <= '0;
      res_q    <= '0;
      npc_q    <= '0;
      wen_q    <= 1'b0;
      out_en_q <= 1'b0;
      out_bus  <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (phase)
        FETCH:  ir <= inst;
        DECODE: begin
          rs1_val <= regs[ir[19:15]];
          rs2_val <= regs[ir[24:20]];
          imm     <= imm_dec;
        end
        EXECUTE: begin
          res_q    <= res;
          npc_q    <= npc;
          wen_q    <= wen;
          out_en_q <= out_en;
        end
        WRITEBACK: begin
          if (wen_q && rd != 5'd0) regs[rd] <= res_q;
          if (out_en_q) out_bus <= res_q;
          pc <= npc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_core.sv
// Directed test bench for main_core: hand-encoded instructions, hand-computed results.
module tb_main_core;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] in_bus;
  logic [31:0] out_bus;

  int checks;
  int errors;

  main_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .in_bus  (in_bus),
    .out_bus (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction for its four cycles and return on the following falling edge.
  task automatic run(input logic [31:0] i, input logic [31:0] bus);
    inst   = i;
    in_bus = bus;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; inst = '0; in_bus = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_bus !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want %h", out_bus, 32'h0); end
    checks++;
    if (dut.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", dut.pc, 32'h0); end
    rst = 1'b1;
    run(32'h00000000, 32'h0);
    checks++;
    if (out_bus !== 32'h0) begin errors++; $display("FAIL nop_out: got %h want %h", out_bus, 32'h0); end
    checks++;
    if (dut.pc !== 32'h4) begin errors++; $display("FAIL nop_pc: got %h want %h", dut.pc, 32'h4); end
  endtask

  task automatic test_upper_jump();
    logic [31:0] ins  [5] = '{32'h1234A0B7, 32'h008000EF, 32'hFFDFF0EF, 32'h008000EF, 32'h22222097};
    logic [31:0] eout [5] = '{32'h1234A000, 32'd12, 32'd20, 32'd16, 32'h22222014};
    logic [31:0] epc  [5] = '{32'd8, 32'd16, 32'd12, 32'd20, 32'd24};
    for (int k = 0; k < 5; k++) begin
      run(ins[k], 32'h0);
      checks++;
      if (out_bus !== eout[k]) begin errors++; $display("FAIL upj_out[%0d]: got %h want %h", k, out_bus, eout[k]); end
      checks++;
      if (dut.pc !== epc[k]) begin errors++; $display("FAIL upj_pc[%0d]: got %h want %h", k, dut.pc, epc[k]); end
    end
  endtask

  task automatic test_load_store();
    run(32'h00000103, 32'd58);
    checks++;
    if (out_bus !== 32'd58) begin errors++; $display("FAIL load_out: got %h want %h", out_bus, 32'd58); end
    run(32'h001101B3, 32'hDEADBEEF);
    checks++;
    if (out_bus !== 32'h2222204E) begin errors++; $display("FAIL add_out: got %h want %h", out_bus, 32'h2222204E); end
    run(32'h0000_0123, 32'h0);
    checks++;
    if (out_bus !== 32'h0) begin errors++; $display("FAIL store_x2_in_place: got %h want %h", out_bus, 32'd0); end
    run(32'h00300023, 32'h0);
    checks++;
    if (out_bus !== 32'h2222204E) begin errors++; $display("FAIL store_out: got %h want %h", out_bus, 32'h2222204E); end
    checks++;
    if (dut.pc !== 32'd40) begin errors++; $display("FAIL store_pc: got %h want %h", dut.pc, 32'd40); end
  endtask

  task automatic test_reset_mid_inst();
    inst = 32'h00700293;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_bus !== 32'h0) begin errors++; $display("FAIL midrst_out: got %h want %h", out_bus, 32'h0); end
    checks++;
    if (dut.pc !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h want %h", dut.pc, 32'h0); end
    @(negedge clk);
    rst = 1'b1;
    run(32'h00500013, 32'h0);
    checks++;
    if (out_bus !== 32'd5) begin errors++; $display("FAIL addi_x0_out: got %h want %h", out_bus, 32'd5); end
    run(32'h00000023, 32'h0);
    checks++;
    if (out_bus !== 32'd0) begin errors++; $display("FAIL x0_reads_zero: got %h want %h", out_bus, 32'd0); end
    run(32'h00500013, 32'h0);
    run(32'h00500023, 32'h0);
    checks++;
    if (out_bus !== 32'd0) begin errors++; $display("FAIL x5_not_written: got %h want %h", out_bus, 32'd0); end
    checks++;
    if (dut.pc !== 32'd16) begin errors++; $display("FAIL midrst_pc_after: got %h want %h", dut.pc, 32'd16); end
  endtask

  task automatic test_alu();
    // x6=-8, x8=15; unknown opcode 0xFFFFFFFF must leave out_bus at 0xFF.
    logic [31:0] ins  [13] = '{32'hFF800313, 32'h40135393, 32'h01C35413, 32'h00032493,
                              32'h00133513, 32'h406405B3, 32'h40835633, 32'h008326B3,
                              32'h00833733, 32'h0F044793, 32'hFFFFFFFF, 32'h10046813,
                              32'h00441893};
    logic [31:0] eout [13] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0000000F, 32'h1,
                              32'h0, 32'h17, 32'hFFFFFFFF, 32'h1,
                              32'h0, 32'hFF, 32'hFF, 32'h10F,
                              32'hF0};
    for (int k = 0; k < 13; k++) begin
      run(ins[k], 32'h0);
      checks++;
      if (out_bus !== eout[k]) begin errors++; $display("FAIL alu_out[%0d] inst %h: got %h want %h", k, ins[k], out_bus, eout[k]); end
    end
    checks++;
    if (dut.pc !== 32'd68) begin errors++; $display("FAIL alu_pc: got %h want %h", dut.pc, 32'd68); end
  endtask

  task automatic test_jalr();
    run(32'h010400E7, 32'h0);
    checks++;
    if (out_bus !== 32'd72) begin errors++; $display("FAIL jalr_link: got %h want %h", out_bus, 32'd72); end
    checks++;
    if (dut.pc !== 32'd30) begin errors++; $display("FAIL jalr_pc: got %h want %h", dut.pc, 32'd30); end
    run(32'h00000000, 32'h0);
    checks++;
    if (dut.pc !== 32'd34) begin errors++; $display("FAIL jalr_next_pc: got %h want %h", dut.pc, 32'd34); end
    checks++;
    if (out_bus !== 32'd72) begin errors++; $display("FAIL nop_hold: got %h want %h", out_bus, 32'd72); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_upper_jump();
    test_load_store();
    test_reset_mid_inst();
    test_alu();
    test_jalr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
